// File: rtl/planificador_ascensor_pkg.sv
// Shared definitions for the elevator scheduler: request codes, motor command
// encodings, controller states and code-to-request-bit mapping helpers.
package paquete_ascensor;

    localparam logic [3:0] COD_CABINA_1 = 4'd1;
    localparam logic [3:0] COD_CABINA_2 = 4'd2;
    localparam logic [3:0] COD_CABINA_3 = 4'd3;
    localparam logic [3:0] COD_CABINA_4 = 4'd4;
    localparam logic [3:0] COD_SUBIR_1  = 4'd5;
    localparam logic [3:0] COD_SUBIR_2  = 4'd6;
    localparam logic [3:0] COD_SUBIR_3  = 4'd7;
    localparam logic [3:0] COD_BAJAR_2  = 4'd8;
    localparam logic [3:0] COD_BAJAR_3  = 4'd9;
    localparam logic [3:0] COD_BAJAR_4  = 4'd10;

    localparam logic [1:0] ACC_PARADO = 2'b00;
    localparam logic [1:0] ACC_SUBIR  = 2'b01;
    localparam logic [1:0] ACC_BAJAR  = 2'b10;

    typedef enum logic [1:0] {REPOSO, SUBIENDO, BAJANDO, PUERTAS} estado_t;

    // Request code k (1..10) owns bit k-1; anything else maps to no bit.
    function automatic logic [9:0] codigo_a_bit(input logic [3:0] codigo);
        codigo_a_bit = '0;
        if (codigo >= COD_CABINA_1 && codigo <= COD_BAJAR_4)
            codigo_a_bit[codigo - 4'd1] = 1'b1;
    endfunction

    function automatic logic [9:0] mascara_cabina(input logic [1:0] p);
        mascara_cabina = 10'd1 << p;
    endfunction

    // Up-hall buttons exist on floors 0..2, down-hall buttons on floors 1..3.
    function automatic logic [9:0] mascara_subir(input logic [1:0] p);
        mascara_subir = (p == 2'd3) ? 10'd0 : (10'd16 << p);
    endfunction

    function automatic logic [9:0] mascara_bajar(input logic [1:0] p);
        mascara_bajar = (p == 2'd0) ? 10'd0 : (10'd64 << p);
    endfunction

endpackage

// File: rtl/planificador_ascensor_temporizador.sv
// Door-open interval counter: held at zero by reiniciar, fin is high on the
// last cycle of a T_PUERTAS-cycle interval.
module temporizador_puertas #(
    parameter int T_PUERTAS = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reiniciar,
    output logic fin
);

    localparam int W = $clog2(T_PUERTAS);

    logic [W-1:0] cuenta;

    assign fin = (cuenta == W'(T_PUERTAS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cuenta <= '0;
        else if (reiniciar)
            cuenta <= '0;
        else if (!fin)
            cuenta <= cuenta + 1'b1;
    end

endmodule

// File: rtl/planificador_ascensor.sv
// Collective up/down trip scheduler for a 4-floor elevator. boton_valido is a
// one-cycle strobe with no back-pressure: the code on boton_pres is taken that cycle.
module planificador_ascensor
    import paquete_ascensor::*;
#(
    parameter int T_PUERTAS = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       boton_valido,
    input  logic [3:0] boton_pres,
    input  logic       sensor_piso,
    output logic [1:0] piso,
    output logic [1:0] accion,
    output logic       puertas,
    output logic [9:0] pendientes,
    output estado_t    estado
);

    estado_t    estado_sig;
    logic       dir, dir_sig;
    logic [1:0] piso_sig, accion_sig;
    logic [9:0] pedir, borrar, serv_aqui;
    logic [3:0] llam;
    logic       reiniciar, fin;

    function automatic logic hay_arriba(input logic [3:0] l, input logic [1:0] p);
        hay_arriba = 1'b0;
        for (int f = 0; f < 4; f++)
            if (f > int'(p) && l[f]) hay_arriba = 1'b1;
    endfunction

    function automatic logic hay_abajo(input logic [3:0] l, input logic [1:0] p);
        hay_abajo = 1'b0;
        for (int f = 0; f < 4; f++)
            if (f < int'(p) && l[f]) hay_abajo = 1'b1;
    endfunction

    // The opposite hall call is only served when nothing waits further on in the travel direction.
    function automatic logic [9:0] servidos(input logic [1:0] p, input logic d, input logic [3:0] l);
        logic mas_alla;
        mas_alla = d ? hay_arriba(l, p) : hay_abajo(l, p);
        servidos = mascara_cabina(p) | (d ? mascara_subir(p) : mascara_bajar(p));
        if (!mas_alla)
            servidos = servidos | (d ? mascara_bajar(p) : mascara_subir(p));
    endfunction

    always_comb begin
        for (int f = 0; f < 4; f++)
            llam[f] = |(pendientes & (mascara_cabina(2'(f)) | mascara_subir(2'(f)) | mascara_bajar(2'(f))));
    end

    temporizador_puertas #(.T_PUERTAS(T_PUERTAS)) u_temporizador (
        .clk       (clk),
        .rst_n     (rst_n),
        .reiniciar (reiniciar),
        .fin       (fin)
    );

    always_comb begin
        estado_sig = estado;
        dir_sig    = dir;
        piso_sig   = piso;
        borrar     = '0;
        reiniciar  = (estado != PUERTAS);
        pedir      = boton_valido ? codigo_a_bit(boton_pres) : 10'd0;
        serv_aqui  = servidos(piso, dir, llam);
        case (estado)
            REPOSO: begin
                if (llam[piso]) begin
                    estado_sig = PUERTAS;
                    borrar     = mascara_cabina(piso) | mascara_subir(piso) | mascara_bajar(piso);
                end else if (hay_arriba(llam, piso)) begin
                    estado_sig = SUBIENDO;
                    dir_sig    = 1'b1;
                end else if (hay_abajo(llam, piso)) begin
                    estado_sig = BAJANDO;
                    dir_sig    = 1'b0;
                end
            end
            SUBIENDO: begin
                if (sensor_piso) begin
                    piso_sig = (piso == 2'd3) ? piso : piso + 2'd1;
                    if (|(pendientes & (mascara_cabina(piso_sig) | mascara_subir(piso_sig))) ||
                        !hay_arriba(llam, piso_sig) || piso_sig == 2'd3) begin
                        estado_sig = PUERTAS;
                        borrar     = servidos(piso_sig, 1'b1, llam);
                    end
                end
            end
            BAJANDO: begin
                if (sensor_piso) begin
                    piso_sig = (piso == 2'd0) ? piso : piso - 2'd1;
                    if (|(pendientes & (mascara_cabina(piso_sig) | mascara_bajar(piso_sig))) ||
                        !hay_abajo(llam, piso_sig) || piso_sig == 2'd0) begin
                        estado_sig = PUERTAS;
                        borrar     = servidos(piso_sig, 1'b0, llam);
                    end
                end
            end
            PUERTAS: begin
                // A call answered by the open doors is dropped and keeps them open longer.
                if (|(pedir & serv_aqui)) begin
                    borrar    = pedir & serv_aqui;
                    reiniciar = 1'b1;
                end else if (fin) begin
                    if (dir ? hay_arriba(llam, piso) : hay_abajo(llam, piso)) begin
                        estado_sig = dir ? SUBIENDO : BAJANDO;
                    end else if (dir ? hay_abajo(llam, piso) : hay_arriba(llam, piso)) begin
                        estado_sig = dir ? BAJANDO : SUBIENDO;
                        dir_sig    = ~dir;
                    end else begin
                        estado_sig = REPOSO;
                    end
                end
            end
            default: estado_sig = REPOSO;
        endcase
    end

    always_comb begin
        accion_sig = ACC_PARADO;
        if (estado_sig == SUBIENDO) accion_sig = ACC_SUBIR;
        else if (estado_sig == BAJANDO) accion_sig = ACC_BAJAR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= REPOSO;
            dir        <= 1'b1;
            piso       <= 2'd0;
            pendientes <= '0;
            accion     <= ACC_PARADO;
            puertas    <= 1'b0;
        end else begin
            estado     <= estado_sig;
            dir        <= dir_sig;
            piso       <= piso_sig;
            pendientes <= (pendientes | pedir) & ~borrar;
            accion     <= accion_sig;
            puertas    <= (estado_sig == PUERTAS);
        end
    end

endmodule

// File: tb/tb_planificador_ascensor.sv
// Bench for planificador_ascensor: a table of request codes plus hand-written
// trip sequences (stops, pass-through, reversal, door restart, mid-trip reset).
module tb_planificador_ascensor;
    import paquete_ascensor::*;

    logic       clk;
    logic       rst_n;
    logic       boton_valido;
    logic [3:0] boton_pres;
    logic       sensor_piso;
    logic [1:0] piso;
    logic [1:0] accion;
    logic       puertas;
    logic [9:0] pendientes;
    estado_t    estado;

    int n_checks = 0;
    int n_fail   = 0;
    int n;
    logic [9:0] exp_q[$];

    typedef struct {
        logic       valido;
        logic [3:0] codigo;
        logic [9:0] pend;
        logic [1:0] acc;
    } vec_t;
    vec_t tabla[12];

    planificador_ascensor #(.T_PUERTAS(50)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .boton_valido (boton_valido),
        .boton_pres   (boton_pres),
        .sensor_piso  (sensor_piso),
        .piso         (piso),
        .accion       (accion),
        .puertas      (puertas),
        .pendientes   (pendientes),
        .estado       (estado)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n        = 1'b0;
        boton_valido = 1'b0;
        boton_pres   = 4'd0;
        sensor_piso  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // drivers
    task automatic pulsar(input logic [3:0] c);
        boton_valido = 1'b1;
        boton_pres   = c;
        tick();
        boton_valido = 1'b0;
        boton_pres   = 4'd0;
    endtask

    task automatic pulso_sensor();
        sensor_piso = 1'b1;
        tick();
        sensor_piso = 1'b0;
    endtask

    task automatic medir_puertas(output int cnt);
        cnt = 0;
        if (puertas) begin
            cnt = 1;
            for (int i = 0; i < 300; i++) begin
                tick();
                if (!puertas) break;
                cnt++;
            end
        end
    endtask

    // scoreboard compare
    task automatic check(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
        end
    endtask

    initial begin
        tabla[0]  = '{1'b1, 4'd4,  10'h008, 2'b00};
        tabla[1]  = '{1'b1, 4'd5,  10'h018, 2'b01};
        tabla[2]  = '{1'b1, 4'd0,  10'h018, 2'b01};
        tabla[3]  = '{1'b1, 4'd11, 10'h018, 2'b01};
        tabla[4]  = '{1'b1, 4'd15, 10'h018, 2'b01};
        tabla[5]  = '{1'b1, 4'd5,  10'h018, 2'b01};
        tabla[6]  = '{1'b0, 4'd7,  10'h018, 2'b01};
        tabla[7]  = '{1'b1, 4'd10, 10'h218, 2'b01};
        tabla[8]  = '{1'b1, 4'd8,  10'h298, 2'b01};
        tabla[9]  = '{1'b1, 4'd1,  10'h299, 2'b01};
        tabla[10] = '{1'b1, 4'd12, 10'h299, 2'b01};
        tabla[11] = '{1'b1, 4'd14, 10'h299, 2'b01};

        // reset values
        reset_dut();
        check("rst_piso", piso, 0);
        check("rst_accion", accion, 0);
        check("rst_puertas", puertas, 0);
        check("rst_pend", pendientes, 0);
        check("rst_estado", estado, REPOSO);

        // code 3 from floor 0: two floors up, stop, door interval, idle
        pulsar(4'd3);
        check("s1_pend_latch", pendientes, 10'h004);
        check("s1_accion_lat", accion, 2'b00);
        tick();
        check("s1_accion_up", accion, 2'b01);
        pulso_sensor();
        check("s1_piso1", piso, 1);
        check("s1_acc_piso1", accion, 2'b01);
        pulso_sensor();
        check("s1_piso2", piso, 2);
        check("s1_puertas", puertas, 1);
        check("s1_acc_stop", accion, 2'b00);
        check("s1_pend_clr", pendientes, 10'h000);
        medir_puertas(n);
        check("s1_t_puertas", n, 50);
        check("s1_estado_fin", estado, REPOSO);
        check("s1_acc_fin", accion, 2'b00);

        // codes 4 and 9: pass floor 3 going up, stop at 4, reverse to 3
        reset_dut();
        pulsar(4'd4);
        pulsar(4'd9);
        check("s2_pend", pendientes, 10'h108);
        check("s2_acc_up", accion, 2'b01);
        pulso_sensor();
        pulso_sensor();
        check("s2_pasa_p2", puertas, 0);
        check("s2_acc_p2", accion, 2'b01);
        pulso_sensor();
        check("s2_piso3", piso, 3);
        check("s2_stop3", puertas, 1);
        check("s2_pend3", pendientes, 10'h100);
        medir_puertas(n);
        check("s2_t_puertas", n, 50);
        check("s2_reversa", accion, 2'b10);
        pulso_sensor();
        check("s2_piso2", piso, 2);
        check("s2_stop2", puertas, 1);
        check("s2_pend_fin", pendientes, 10'h000);

        // up-hall call at floor 2 caught on the way up, then continue
        reset_dut();
        pulsar(4'd4);
        pulsar(4'd6);
        check("s3_pend", pendientes, 10'h028);
        check("s3_acc", accion, 2'b01);
        pulso_sensor();
        check("s3_piso1", piso, 1);
        check("s3_stop", puertas, 1);
        check("s3_pend_clr", pendientes, 10'h008);
        medir_puertas(n);
        check("s3_t_puertas", n, 50);
        check("s3_sigue", accion, 2'b01);
        pulso_sensor();
        pulso_sensor();
        check("s3_piso3", piso, 3);
        check("s3_stop3", puertas, 1);
        check("s3_pend_fin", pendientes, 10'h000);

        // served request during door interval restarts it
        reset_dut();
        pulsar(4'd2);
        tick();
        pulso_sensor();
        check("s4_stop", puertas, 1);
        n = 1;
        for (int i = 0; i < 29; i++) begin
            tick();
            if (puertas) n++;
        end
        pulsar(4'd2);
        if (puertas) n++;
        check("s4_pend_no_set", pendientes, 10'h000);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!puertas) break;
            n++;
        end
        check("s4_t_total", n, 80);
        check("s4_reposo", estado, REPOSO);

        // request table while travelling up from floor 0 (no sensor pulses)
        reset_dut();
        foreach (tabla[i]) exp_q.push_back(tabla[i].pend);
        foreach (tabla[i]) begin
            logic [9:0] e;
            boton_valido = tabla[i].valido;
            boton_pres   = tabla[i].codigo;
            tick();
            boton_valido = 1'b0;
            boton_pres   = 4'd0;
            e = exp_q.pop_front();
            check($sformatf("tab_pend_%0d", i), pendientes, e);
            check($sformatf("tab_acc_%0d", i), accion, tabla[i].acc);
        end

        // reset while moving down, then sensor pulses while idle
        reset_dut();
        pulsar(4'd2);
        tick();
        pulso_sensor();
        pulsar(4'd1);
        check("s6_pend", pendientes, 10'h001);
        medir_puertas(n);
        check("s6_baja", accion, 2'b10);
        rst_n = 1'b0;
        tick();
        check("s6_rst_piso", piso, 0);
        check("s6_rst_acc", accion, 0);
        check("s6_rst_puertas", puertas, 0);
        check("s6_rst_pend", pendientes, 0);
        rst_n = 1'b1;
        pulso_sensor();
        pulso_sensor();
        check("s6_piso_quieto", piso, 0);
        check("s6_acc_quieto", accion, 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
